// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-queued load results onto the register-file
// write port, with load anti-starvation and PC redirect on index 63. Optional WB_FORWARD_EN adds fwd_* bypass outputs.
module writeback_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [5:0]  alu_index,
    input  logic [63:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [5:0]  mem_index,
    input  logic [63:0] mem_data,
    output logic        write_en,
    output logic [5:0]  write_index,
    output logic [63:0] write_data,
    output logic        pc_write_en,
`ifdef WB_FORWARD_EN
    output logic        fwd_valid,
    output logic [5:0]  fwd_index,
    output logic [63:0] fwd_data,
`endif
    output logic [63:0] pc_data
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ST_W  = 8;
    localparam logic [5:0]  PC_INDEX = 6'h3F;

    typedef struct packed {
        logic [5:0]  index;
        logic [63:0] data;
    } wb_entry_t;

    wb_entry_t        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [ST_W-1:0]  starve;
    logic [ST_W-1:0]  starve_next;
    logic             fifo_empty;
    logic             starved;
    logic             push;
    logic             pop;
    logic             sel_valid;
    wb_entry_t        sel;

    // Source select, handshakes and queue bookkeeping for this cycle
    always_comb begin
        fifo_empty = (count == '0);
        starved    = !fifo_empty && (starve == ST_W'(STARVE_LIMIT));
        mem_ready  = !rst && (count != CNT_W'(FIFO_DEPTH));
        alu_ready  = !rst && !starved;
        push       = mem_valid && mem_ready;
        pop        = 1'b0;
        sel_valid  = 1'b0;
        sel        = '0;
        if (!rst) begin
            if (starved) begin
                pop       = 1'b1;
                sel_valid = 1'b1;
                sel       = fifo_mem[rd_ptr];
            end else if (alu_valid) begin
                sel_valid = 1'b1;
                sel       = '{index: alu_index, data: alu_data};
            end else if (!fifo_empty) begin
                pop       = 1'b1;
                sel_valid = 1'b1;
                sel       = fifo_mem[rd_ptr];
            end
        end
        count_next = count + CNT_W'(push) - CNT_W'(pop);
        // Counter measures how long the current head has been waiting
        if (pop || (count_next == '0)) begin
            starve_next = '0;
        end else if (starve == ST_W'(STARVE_LIMIT)) begin
            starve_next = starve;
        end else begin
            starve_next = starve + ST_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{index: mem_index, data: mem_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            starve <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count_next;
            starve <= starve_next;
        end
    end

    // Registered write port; index 63 is steered to the PC redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            write_en    <= 1'b0;
            write_index <= '0;
            write_data  <= '0;
            pc_write_en <= 1'b0;
            pc_data     <= '0;
        end else begin
            write_en    <= 1'b0;
            pc_write_en <= 1'b0;
            if (sel_valid) begin
                if (sel.index == PC_INDEX) begin
                    pc_write_en <= 1'b1;
                    pc_data     <= sel.data;
                end else begin
                    write_en    <= 1'b1;
                    write_index <= sel.index;
                    write_data  <= sel.data;
                end
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_valid = sel_valid && (sel.index != PC_INDEX);
    assign fwd_index = sel.index;
    assign fwd_data  = sel.data;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_writeback_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    typedef struct {
        logic [5:0]  index;
        logic [63:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [5:0]  alu_index, mem_index, write_index;
    logic [63:0] alu_data, mem_data, write_data, pc_data;
    logic        write_en, pc_write_en;
`ifdef WB_FORWARD_EN
    logic        fwd_valid;
    logic [5:0]  fwd_index;
    logic [63:0] fwd_data;
`endif

    writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_index(alu_index), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_index(mem_index), .mem_data(mem_data),
        .write_en(write_en), .write_index(write_index), .write_data(write_data),
        .pc_write_en(pc_write_en),
`ifdef WB_FORWARD_EN
        .fwd_valid(fwd_valid), .fwd_index(fwd_index), .fwd_data(fwd_data),
`endif
        .pc_data(pc_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    entry_t      q[$];
    int          starve = 0;
    logic        m_we = 0, m_pe = 0;
    logic [5:0]  m_wi = 0;
    logic [63:0] m_wd = 0, m_pd = 0;
    logic        last_aready, last_mready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: inputs already applied; checks combinational then registered outputs
    task automatic cycle();
        entry_t e;
        bit     have, popped, starved, m_ar, m_mr;
        #1;
        last_aready = alu_ready;
        last_mready = mem_ready;
        have = 0; popped = 0; starved = 0;
        if (rst) begin
            m_ar = 0; m_mr = 0;
        end else begin
            starved = (q.size() > 0) && (starve == LIMIT);
            m_ar = !starved;
            m_mr = (q.size() != DEPTH);
        end
        chk("alu_ready", alu_ready, m_ar);
        chk("mem_ready", mem_ready, m_mr);
        if (!rst) begin
            if (starved) begin
                e = q.pop_front(); have = 1; popped = 1;
            end else if (alu_valid) begin
                e.index = alu_index; e.data = alu_data; have = 1;
            end else if (q.size() > 0) begin
                e = q.pop_front(); have = 1; popped = 1;
            end
        end
`ifdef WB_FORWARD_EN
        chk("fwd_valid", fwd_valid, have && e.index != 6'h3F);
        if (rst || (have && e.index != 6'h3F)) begin
            chk("fwd_index", fwd_index, rst ? 6'd0 : e.index);
            chk("fwd_data", fwd_data, rst ? 64'd0 : e.data);
        end
`endif
        if (rst) begin
            q.delete(); starve = 0;
            m_we = 0; m_pe = 0; m_wi = 0; m_wd = 0; m_pd = 0;
        end else begin
            if (mem_valid && m_mr) begin
                entry_t n;
                n.index = mem_index; n.data = mem_data;
                q.push_back(n);
            end
            if (popped || q.size() == 0) starve = 0;
            else if (starve < LIMIT) starve++;
            m_we = 0; m_pe = 0;
            if (have) begin
                if (e.index == 6'h3F) begin m_pe = 1; m_pd = e.data; end
                else begin m_we = 1; m_wi = e.index; m_wd = e.data; end
            end
        end
        @(posedge clk);
        #1;
        chk("write_en", write_en, m_we);
        chk("write_index", write_index, m_wi);
        chk("write_data", write_data, m_wd);
        chk("pc_write_en", pc_write_en, m_pe);
        chk("pc_data", pc_data, m_pd);
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_index = 0; alu_data = 0;
        mem_valid = 0; mem_index = 0; mem_data = 0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs();
        cycle(); cycle();
        rst = 0;
    endtask

    initial begin
        logic [5:0] retired[$];
        int i;
        rst = 1; idle_inputs();
        @(posedge clk); #1;
        do_reset();
        chk("reset_write_en", write_en, 1'b0);
        chk("reset_pc_data", pc_data, 64'd0);

        // ALU register write, then idle
        alu_valid = 1; alu_index = 6'd5; alu_data = 64'h1234;
        cycle();
        chk("t1_we", write_en, 1'b1);
        chk("t1_idx", write_index, 6'd5);
        chk("t1_data", write_data, 64'h1234);
        idle_inputs();
        cycle();
        chk("t1_we_off", write_en, 1'b0);

        // PC redirect
        alu_valid = 1; alu_index = 6'h3F; alu_data = 64'h400;
        cycle();
        chk("t2_pc_we", pc_write_en, 1'b1);
        chk("t2_pc_data", pc_data, 64'h400);
        chk("t2_we", write_en, 1'b0);
        idle_inputs();
        cycle();

        // FIFO fill under ALU pressure and in-order drain
        do_reset();
        alu_valid = 1; alu_index = 6'd20; alu_data = 64'hA;
        i = 1;
        for (int c = 0; c < 200 && retired.size() < 5; c++) begin
            mem_valid = (i <= 5);
            mem_index = 6'(i); mem_data = 64'(100 + i);
            cycle();
            if (c == 4) chk("t3_full", last_mready, 1'b0);
            if (mem_valid && last_mready) i++;
            if (write_en && write_index != 6'd20) retired.push_back(write_index);
        end
        chk("t3_count", retired.size(), 5);
        for (int j = 0; j < 5 && j < retired.size(); j++) chk("t3_order", retired[j], 6'(j + 1));

        // Starvation timer with one queued load
        do_reset();
        alu_valid = 1; alu_index = 6'd20; alu_data = 64'hA;
        mem_valid = 1; mem_index = 6'd9; mem_data = 64'h99;
        cycle();
        mem_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            chk("t4_alu_ready", last_aready, k < 8);
        end
        chk("t4_load_idx", write_index, 6'd9);
        chk("t4_load_data", write_data, 64'h99);
        cycle();
        chk("t4_ready_back", last_aready, 1'b1);

        // Reset discards queued loads
        do_reset();
        alu_valid = 1; alu_index = 6'd20; alu_data = 64'hA;
        for (int k = 1; k <= 3; k++) begin
            mem_valid = 1; mem_index = 6'(k); mem_data = 64'(k);
            cycle();
        end
        idle_inputs(); rst = 1;
        cycle();
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t5_no_write", write_en, 1'b0);
            chk("t5_no_pc", pc_write_en, 1'b0);
            chk("t5_mem_ready", last_mready, 1'b1);
        end

        // Randomized traffic including collisions, PC index and occasional reset
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 63) == 0);
            alu_valid = ($urandom_range(0, 1) == 1);
            alu_index = ($urandom_range(0, 7) == 0) ? 6'h3F : 6'($urandom_range(0, 7));
            alu_data  = {$urandom, $urandom};
            mem_valid = ($urandom_range(0, 9) < 6);
            mem_index = ($urandom_range(0, 7) == 0) ? 6'h3F : 6'($urandom_range(0, 7));
            mem_data  = {$urandom, $urandom};
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
